reg_bank_dp: RTL
================

# reg_bank_dp

Parametrised two-port configuration register bank, the successor to the 8x16 single-port register file. Separate write and read ports may both be used in the same cycle, with per-bit write masking, parameterised reset contents, read-only protection, a configurable read pipeline and change-notify pulses on the exposed configuration registers. Sits between the system controller (command decode) and the ALU, UART and clock-divider configuration inputs.

## Interface
- DATA_WIDTH, 8: register width in bits
- DEPTH, 16: number of registers, 2..2^ADDR_WIDTH
- ADDR_WIDTH, 4: address width
- NUM_CFG, 4: registers 0..NUM_CFG-1 driven continuously on CfgRegs, 1..DEPTH
- RESET_VALUES, {reg3=0x20, reg2=0x81, others 0}: flat DEPTH*DATA_WIDTH vector, register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- RO_MASK, 0: DEPTH bits, bit i=1 makes register i read-only
- RD_LATENCY, 1: read latency in cycles, 1 or 2
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- WrEn  in  1  write request
- WrAddr  in  ADDR_WIDTH  write address
- WrData  in  DATA_WIDTH  write data
- WrMask  in  DATA_WIDTH  bit-enable, 1 = bit updated
- RdEn  in  1  read request
- RdAddr  in  ADDR_WIDTH  read address
- RdData  out  DATA_WIDTH  read data, zero when RdData_Valid low
- RdData_Valid  out  1  one-cycle pulse per accepted read
- RdErr  out  1  pulses with RdData_Valid when the read address was out of range
- WrErr  out  1  one-cycle pulse, cycle after a rejected write
- CfgRegs  out  NUM_CFG*DATA_WIDTH  live contents of registers 0..NUM_CFG-1
- CfgUpdate  out  NUM_CFG  bit i pulses one cycle after a write changes register i

## Operation
- Reset (RST low, async): register i <= RESET_VALUES slice i; RdData, RdData_Valid, RdErr, WrErr, CfgUpdate <= 0; read pipeline flushed. CfgRegs reflects the defaults immediately.
- Write, on the edge with WrEn=1: reg[WrAddr] <= (reg & ~WrMask) | (WrData & WrMask).
- Rejected write: WrAddr >= DEPTH or RO_MASK[WrAddr]=1 -> no state change, WrErr=1 next cycle. WrMask=0 is a legal no-op with no error.
- CfgUpdate[i]=1 next cycle only if i < NUM_CFG, the write was accepted and the new value differs from the old one.
- Read: RdEn=1 captures the data at the issue edge. RdAddr >= DEPTH returns 0 with RdErr=1.
- Simultaneous write and read to the same address: the read returns the post-write (masked-merged) value (write-first bypass).
- Read and write to different addresses in the same cycle are independent, with no stall.
- The read port accepts a new request every cycle at either latency. No backpressure.

## Timing
- RD_LATENCY=1: RdEn at edge N -> RdData/RdData_Valid/RdErr valid in cycle N..N+1 (registered once).
- RD_LATENCY=2: one extra output register; valid one cycle later. The data is fixed at issue, so a write to the same address in the following cycle is not reflected.
- Write visible on CfgRegs and to reads issued the cycle after the write edge. Bypass covers the same cycle.
- WrErr and CfgUpdate are registered with 1-cycle latency and cannot overlap for the same write.
- Reset asserted mid-read drops the in-flight read: no valid pulse after reset release.

## Structure
- Package reg_bank_pkg holds the default RESET_VALUES constant for the current system map (REG0/1=0, REG2=0x81 meaning prescale 32, parity enable, even parity; REG3=0x20 meaning divider 32), register index constants, and the bounds check for RD_LATENCY.
- Sub-module reg_bank_rd_pipe: a latency-parametrised valid/data/err delay line (1 or 2 stages) with async reset. The storage array, write logic, bypass and change detection live in the top.
- The storage array has no reset-to-zero loop; it is loaded from RESET_VALUES.

## Test plan
- Reset, no traffic -> CfgRegs = {0x20,0x81,0x00,0x00}; read of addr 2 returns 0x81 with Valid one cycle after RdEn; outputs 0 during reset.
- Write addr 5 = 0xF0 with mask 0x3C over an initial value of 0x0F -> read returns 0x33; mask 0x00 -> value unchanged, WrErr=0.
- Same-cycle WrEn/RdEn to addr 1, data 0xAA -> RdData=0xAA next cycle; CfgUpdate[1] pulses once; writing 0xAA again -> no CfgUpdate.
- RO_MASK[3]=1, write 0x10 to addr 3 -> WrErr pulse, CfgRegs[3] stays 0x20; with DEPTH=12, read addr 13 -> RdData=0, Valid=1, RdErr=1.
- RD_LATENCY=2, back-to-back reads of addrs 0..3 -> four consecutive Valid pulses starting 2 cycles after the first RdEn, in order, with correct data.
- Assert RST one cycle after RdEn (latency 2) -> no Valid pulse is emitted and all registers return to RESET_VALUES asynchronously.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants for the two-port configuration register bank:
// system register map defaults, register indices and latency bounds.
package reg_bank_pkg;

  localparam int unsigned MAP_DEPTH = 16;
  localparam int unsigned MAP_DW    = 8;

  localparam int unsigned REG_ALU    = 0;
  localparam int unsigned REG_CTRL   = 1;
  localparam int unsigned REG_UART   = 2;
  localparam int unsigned REG_CLKDIV = 3;

  // prescale 32, parity enable, even parity
  localparam logic [MAP_DW-1:0] UART_DEF   = 8'h81;
  // divider 32
  localparam logic [MAP_DW-1:0] CLKDIV_DEF = 8'h20;

  function automatic logic [MAP_DEPTH*MAP_DW-1:0] map_defaults();
    logic [MAP_DEPTH*MAP_DW-1:0] v;
    v = '0;
    v[REG_ALU*MAP_DW +: MAP_DW]    = '0;
    v[REG_CTRL*MAP_DW +: MAP_DW]   = '0;
    v[REG_UART*MAP_DW +: MAP_DW]   = UART_DEF;
    v[REG_CLKDIV*MAP_DW +: MAP_DW] = CLKDIV_DEF;
    return v;
  endfunction

  localparam logic [MAP_DEPTH*MAP_DW-1:0] RESET_VALUES_DEF =
    map_defaults();

  function automatic bit rd_lat_ok(int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic int unsigned rd_lat_fix(int unsigned lat);
    return rd_lat_ok(lat) ? lat : 1;
  endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Write/read command bus between the system controller and the
// configuration register bank.
interface reg_bank_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);

  logic                  WrEn;
  logic [ADDR_WIDTH-1:0] WrAddr;
  logic [DATA_WIDTH-1:0] WrData;
  logic [DATA_WIDTH-1:0] WrMask;
  logic                  RdEn;
  logic [ADDR_WIDTH-1:0] RdAddr;
  logic [DATA_WIDTH-1:0] RdData;
  logic                  RdData_Valid;
  logic                  RdErr;
  logic                  WrErr;

  modport master (
    output WrEn, WrAddr, WrData, WrMask,
    output RdEn, RdAddr,
    input  RdData, RdData_Valid, RdErr, WrErr
  );

  modport slave (
    input  WrEn, WrAddr, WrData, WrMask,
    input  RdEn, RdAddr,
    output RdData, RdData_Valid, RdErr, WrErr
  );

endinterface

// File: rtl/reg_bank_rd_pipe.sv
// Read-response delay line, one or two register stages deep.
// Data and error are forced to zero whenever the stage is not valid.
module reg_bank_rd_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LAT        = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_vld,
  input  logic                  in_err,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vld,
  output logic                  out_err,
  output logic [DATA_WIDTH-1:0] out_data
);

  typedef struct packed {
    logic                  vld;
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } stg_t;

  stg_t stg_d;
  stg_t stg_q [LAT];

  always_comb begin
    stg_d      = '0;
    stg_d.vld  = in_vld;
    stg_d.err  = in_vld & in_err;
    stg_d.data = in_vld ? in_data : '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < LAT; i++)
        stg_q[i] <= '0;
    end else begin
      stg_q[0] <= stg_d;
      for (int i = 1; i < LAT; i++)
        stg_q[i] <= stg_q[i-1];
    end
  end

  assign out_vld  = stg_q[LAT-1].vld;
  assign out_err  = stg_q[LAT-1].err;
  assign out_data = stg_q[LAT-1].data;

endmodule

// File: rtl/reg_bank_dp.sv
// Two-port configuration register bank: masked writes, read-only
// protection, write-first bypass, change pulses on config registers.
module reg_bank_dp
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_CFG    = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0] RESET_VALUES =
    (DEPTH*DATA_WIDTH)'(RESET_VALUES_DEF),
  parameter logic [DEPTH-1:0] RO_MASK = '0,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  reg_bank_if.slave                     bus,
  output logic [NUM_CFG*DATA_WIDTH-1:0] CfgRegs,
  output logic [NUM_CFG-1:0]            CfgUpdate
);

  localparam int unsigned LAT = rd_lat_fix(RD_LATENCY);
  localparam int unsigned AW1 = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] DEPTH_A = AW1'(DEPTH);
  localparam logic [2**ADDR_WIDTH-1:0] RO_EXT =
    (2**ADDR_WIDTH)'(RO_MASK);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_rng;
  logic                  wr_ok;
  logic                  wr_chg;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_new;
  logic                  rd_rng;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [NUM_CFG-1:0]    upd_d;
  logic                  wr_err_q;

  assign wr_rng = {1'b0, bus.WrAddr} < DEPTH_A;
  assign wr_ok  = bus.WrEn & wr_rng & ~RO_EXT[bus.WrAddr];
  assign wr_old = wr_rng ? mem[bus.WrAddr] : '0;
  assign wr_new = (wr_old & ~bus.WrMask) |
                  (bus.WrData & bus.WrMask);
  assign wr_chg = wr_new != wr_old;

  assign rd_rng = {1'b0, bus.RdAddr} < DEPTH_A;
  assign rd_hit = wr_ok & (bus.WrAddr == bus.RdAddr);

  // Same-address write wins: the read sees the merged value.
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      !rd_rng: rd_val = '0;
      rd_hit:  rd_val = wr_new;
      default: rd_val = mem[bus.RdAddr];
    endcase
  end

  always_comb begin
    upd_d = '0;
    for (int i = 0; i < NUM_CFG; i++)
      upd_d[i] = wr_ok & wr_chg &
                 ({1'b0, bus.WrAddr} == AW1'(i));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
    end else if (wr_ok) begin
      mem[bus.WrAddr] <= wr_new;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CfgUpdate <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      CfgUpdate <= upd_d;
      wr_err_q  <= bus.WrEn & ~wr_ok;
    end
  end

  assign bus.WrErr = wr_err_q;

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
    assign CfgRegs[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
  end

  reg_bank_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LAT        (LAT)
  ) u_rd_pipe (
    .CLK      (CLK),
    .RST      (RST),
    .in_vld   (bus.RdEn),
    .in_err   (~rd_rng),
    .in_data  (rd_val),
    .out_vld  (bus.RdData_Valid),
    .out_err  (bus.RdErr),
    .out_data (bus.RdData)
  );

endmodule
